// File: rtl/kbd_matrix_pkg.sv
// kbd_matrix shared types: applier states, queued event layout, keymap modes.
// Optional HOLD stage is enabled with KBD_MATRIX_HOLD_EN.
package kbd_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        HOLD,
        RESYNC
    } kbd_state_t;

    // row/col fields sized for the 16x16 maximum matrix
    typedef struct packed {
        logic       pressed;
        logic       is_aux;
        logic [3:0] row;
        logic [3:0] col;
    } kbd_event_t;

    localparam logic [1:0] KBD_MODE_STD = 2'd0;
    localparam logic [1:0] KBD_MODE_MX  = 2'd1;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int col_w(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

endpackage

// File: rtl/kbd_matrix_if.sv
// Key matrix scan port: select lines from the PPI, sense lines back to it.
// master = machine side, slave = emulator side.
interface kbd_matrix_if #(
    parameter int ROWS = 6,
    parameter int COLS = 12
);
    logic [ROWS-1:0] row_in;
    logic [ROWS-1:0] row_out;
    logic [COLS-1:0] col_in;
    logic [COLS-1:0] col_out;

    modport master (
        output row_in,
        output col_in,
        input  row_out,
        input  col_out
    );

    modport slave (
        input  row_in,
        input  col_in,
        output row_out,
        output col_out
    );
endinterface

// File: rtl/kbd_matrix_keymap.sv
// Combinational PS/2 scancode table; row/col packed as hi/lo nibble.
// Positions outside ROWS x COLS are reported invalid.
module kbd_keymap
    import kbd_matrix_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 12
) (
    input  logic [1:0] mode,
    input  logic       ext,
    input  logic [7:0] code,
    output logic       valid,
    output logic       is_aux,
    output logic [3:0] row,
    output logic [3:0] col
);
    logic       hit;
    logic [7:0] rc;

    always_comb begin
        hit    = 1'b1;
        is_aux = 1'b0;
        rc     = 8'h00;
        case ({ext, code})
            9'h01C: rc = 8'h82;
            9'h032: rc = 8'h00;
            9'h021: rc = 8'h13;
            9'h023: rc = 8'h24;
            9'h024: rc = 8'h35;
            9'h02B: rc = 8'h46;
            9'h034: rc = 8'h57;
            9'h033: rc = 8'h68;
            9'h043: rc = 8'h79;
            9'h03B: rc = 8'hAA;
            9'h042: rc = 8'hBB;
            9'h005: rc = (mode == KBD_MODE_MX) ? 8'h95 : 8'hC0;
            9'h175: rc = 8'hD1;
            9'h012: begin is_aux = 1'b1; rc = 8'h00; end
            9'h014: begin is_aux = 1'b1; rc = 8'h01; end
            default: hit = 1'b0;
        endcase
        row   = rc[7:4];
        col   = rc[3:0];
        valid = hit
              && (mode == KBD_MODE_STD || mode == KBD_MODE_MX)
              && (is_aux || (int'(row) < ROWS && int'(col) < COLS));
    end
endmodule

// File: rtl/kbd_matrix.sv
// PS/2 to key-matrix emulator: keymap decode, event FIFO, timed applier.
// Define KBD_MATRIX_HOLD_EN to keep each applied event for HOLD_CYCLES.
module kbd_matrix
    import kbd_matrix_pkg::*;
#(
    parameter int ROWS        = 6,
    parameter int COLS        = 12,
    parameter int AUX_N       = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 65536
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    input  logic [1:0]       mode,
    kbd_matrix_if.slave      scan,
    output logic [AUX_N-1:0] aux,
    output logic             overflow,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    kbd_state_t state, state_n;
    kbd_event_t ev_in, cur;
    kbd_event_t fifo_mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic [ROWS-1:0][COLS-1:0] matrix;
    logic strobe_q, km_valid, km_aux;
    logic [3:0] km_row, km_col;
    logic evt, empty, full, push, pop, drop;
    logic [COLS-1:0] col_s;
    logic [ROWS-1:0] row_s;

    kbd_keymap #(.ROWS(ROWS), .COLS(COLS)) u_keymap (
        .mode  (mode),
        .ext   (ps2_key[8]),
        .code  (ps2_key[7:0]),
        .valid (km_valid),
        .is_aux(km_aux),
        .row   (km_row),
        .col   (km_col)
    );

    always_comb begin
        ev_in.pressed = ps2_key[9];
        ev_in.is_aux  = km_aux;
        ev_in.row     = km_row;
        ev_in.col     = km_col;
    end

    assign evt   = (ps2_key[10] != strobe_q) && km_valid;
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = (state == IDLE) && !empty;
    assign push  = evt && (!full || pop);
    assign drop  = evt && full && !pop;
    assign busy  = !empty || (state != IDLE);

    // loaded during reset too, so a held strobe level is not an event
    always_ff @(posedge clk_sys) strobe_q <= ps2_key[10];

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wp[AW-1:0]] <= ev_in;
        if (pop) cur <= fifo_mem[rp[AW-1:0]];
    end

`ifdef KBD_MATRIX_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) hold_cnt <= '0;
        else if (state == APPLY) hold_cnt <= HW'(HOLD_CYCLES - 1);
        else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!empty) state_n = APPLY;
                else if (overflow) state_n = RESYNC;
            end
`ifdef KBD_MATRIX_HOLD_EN
            APPLY: state_n = HOLD;
            HOLD: if (hold_cnt == '0) state_n = IDLE;
`else
            APPLY: state_n = IDLE;
            HOLD: state_n = IDLE;
`endif
            RESYNC: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            matrix   <= '0;
            aux      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (drop) overflow <= 1'b1;
            else if (state == RESYNC) overflow <= 1'b0;
            if (state == APPLY) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if (!cur.is_aux && cur.row == 4'(r) && cur.col == 4'(c))
                            matrix[r][c] <= cur.pressed;
                for (int a = 0; a < AUX_N; a++)
                    if (cur.is_aux && cur.col == 4'(a))
                        aux[a] <= cur.pressed;
            end
            if (state == RESYNC) begin
                matrix <= '0;
                aux    <= '0;
            end
        end
    end

    always_comb begin
        col_s = '1;
        row_s = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (matrix[r][c] && !scan.row_in[r]) col_s[c] = 1'b0;
                if (matrix[r][c] && !scan.col_in[c]) row_s[r] = 1'b0;
            end
    end

    assign scan.col_out = col_s;
    assign scan.row_out = row_s;
endmodule

// File: tb/tb_kbd_matrix.sv
// Scoreboard bench for kbd_matrix: latency, hold spacing, overflow/resync,
// aux keys, layout select and reset with a loaded queue.
module tb_kbd_matrix;
    localparam int ROWS  = 16;
    localparam int COLS  = 12;
    localparam int AUX_N = 2;
    localparam int DEPTH = 4;
    localparam int HOLD  = 16;
`ifdef KBD_MATRIX_HOLD_EN
    localparam int S  = HOLD + 2;
    localparam int NB = 6;
`else
    localparam int S  = 2;
    localparam int NB = 9;
`endif

    typedef struct packed {
        logic       pressed;
        logic       is_aux;
        logic [3:0] row;
        logic [3:0] col;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [1:0] mode = '0;
    logic [AUX_N-1:0] aux;
    logic overflow, busy;

    exp_t sbq[$];
    logic [ROWS-1:0][COLS-1:0] model;
    logic [AUX_N-1:0] model_aux;
    int n_tests = 0;
    int n_fail = 0;

    logic [8:0] bk [9] = '{9'h032, 9'h021, 9'h023, 9'h024, 9'h02B,
                           9'h034, 9'h033, 9'h043, 9'h03B};
    int br [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 10};
    int bc [9] = '{0, 3, 4, 5, 6, 7, 8, 9, 10};

    kbd_matrix_if #(.ROWS(ROWS), .COLS(COLS)) scan ();

    kbd_matrix #(
        .ROWS(ROWS), .COLS(COLS), .AUX_N(AUX_N),
        .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .ps2_key (ps2_key),
        .mode    (mode),
        .scan    (scan),
        .aux     (aux),
        .overflow(overflow),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [COLS-1:0] exp_col(input logic [ROWS-1:0] rsel);
        exp_col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (model[r][c] && !rsel[r]) exp_col[c] = 1'b0;
    endfunction

    function automatic logic [ROWS-1:0] exp_row(input logic [COLS-1:0] csel);
        exp_row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (model[r][c] && !csel[c]) exp_row[r] = 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int r, input int c);
        scan.row_in = ~(ROWS'(1) << r);
        scan.col_in = ~(COLS'(1) << c);
        #1;
    endtask

    task automatic send(input logic [8:0] key, input logic pressed,
                        input logic ok, input logic is_aux,
                        input int row, input int col);
        exp_t e;
        ps2_key = {~ps2_key[10], pressed, key};
        e.pressed = pressed;
        e.is_aux  = is_aux;
        e.row     = 4'(row);
        e.col     = 4'(col);
        if (ok) sbq.push_back(e);
    endtask

    task automatic apply_next();
        exp_t e;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got empty queue, want an entry");
        end else begin
            e = sbq.pop_front();
            for (int a = 0; a < AUX_N; a++)
                if (e.is_aux && int'(e.col) == a) model_aux[a] = e.pressed;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (!e.is_aux && int'(e.row) == r && int'(e.col) == c)
                        model[r][c] = e.pressed;
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 400) begin
            tick(1);
            k++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scan.row_in = '1;
        scan.col_in = '1;
        model = '0;
        model_aux = '0;
        tick(2);
        reset = 1'b0;
        scan.row_in = '0;
        scan.col_in = '0;
        #1;
        n_tests++;
        if (scan.col_out !== 12'hFFF) begin
            n_fail++; $display("FAIL rst_col_out: got %h want fff", scan.col_out);
        end
        n_tests++;
        if (scan.row_out !== 16'hFFFF) begin
            n_fail++; $display("FAIL rst_row_out: got %h want ffff", scan.row_out);
        end
        n_tests++;
        if (aux !== 2'b00) begin
            n_fail++; $display("FAIL rst_aux: got %b want 00", aux);
        end
        n_tests++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_flags: got ovf=%b busy=%b want 0 0", overflow, busy);
        end
    endtask

    task automatic test_press_a();
        send(9'h01C, 1'b1, 1'b1, 1'b0, 8, 2);
        tick(2);
        probe(8, 2);
        n_tests++;
        if (scan.col_out !== 12'hFFF) begin
            n_fail++; $display("FAIL a_early: got %h want fff", scan.col_out);
        end
        tick(1);
        apply_next();
        probe(8, 2);
        n_tests++;
        if (scan.col_out !== 12'hFFB) begin
            n_fail++; $display("FAIL a_col_out: got %h want ffb", scan.col_out);
        end
        n_tests++;
        if (scan.row_out !== 16'hFEFF) begin
            n_fail++; $display("FAIL a_row_out: got %h want feff", scan.row_out);
        end
        probe(9, 3);
        n_tests++;
        if (scan.col_out !== exp_col(scan.row_in) || scan.row_out !== exp_row(scan.col_in)) begin
            n_fail++; $display("FAIL a_other_sel: got %h/%h want %h/%h", scan.col_out,
                               scan.row_out, exp_col(scan.row_in), exp_row(scan.col_in));
        end
        wait_idle("a_press");
        send(9'h01C, 1'b0, 1'b1, 1'b0, 8, 2);
        tick(3);
        apply_next();
        probe(8, 2);
        n_tests++;
        if (scan.col_out !== 12'hFFF) begin
            n_fail++; $display("FAIL a_release: got %h want fff", scan.col_out);
        end
        wait_idle("a_release");
    endtask

    task automatic test_hold();
        send(9'h01C, 1'b1, 1'b1, 1'b0, 8, 2);
        tick(1);
        send(9'h01C, 1'b0, 1'b1, 1'b0, 8, 2);
        tick(2);
        apply_next();
        probe(8, 2);
        n_tests++;
        if (scan.col_out !== 12'hFFB) begin
            n_fail++; $display("FAIL hold_set: got %h want ffb", scan.col_out);
        end
        tick(S - 1);
        n_tests++;
        if (scan.col_out !== 12'hFFB || busy !== 1'b1) begin
            n_fail++; $display("FAIL hold_kept: got %h busy=%b want ffb busy=1", scan.col_out, busy);
        end
        tick(1);
        apply_next();
        n_tests++;
        if (scan.col_out !== 12'hFFF) begin
            n_fail++; $display("FAIL hold_clear: got %h want fff", scan.col_out);
        end
        tick(S - 2);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_busy_drop: got %b want 0", busy);
        end
    endtask

    task automatic test_burst_overflow();
        for (int i = 0; i < NB; i++) begin
            send(bk[i], 1'b1, (i < NB - 1), 1'b0, br[i], bc[i]);
            tick(1);
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL burst_ovf_set: got %b want 1", overflow);
        end
        tick(3 + (NB - 2) * S - NB);
        for (int i = 0; i < NB - 1; i++) apply_next();
        scan.row_in = '0;
        scan.col_in = '0;
        #1;
        n_tests++;
        if (scan.col_out !== exp_col(scan.row_in)) begin
            n_fail++; $display("FAIL burst_cols: got %h want %h", scan.col_out, exp_col(scan.row_in));
        end
        n_tests++;
        if (scan.row_out !== exp_row(scan.col_in)) begin
            n_fail++; $display("FAIL burst_rows: got %h want %h", scan.row_out, exp_row(scan.col_in));
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL burst_ovf_held: got %b want 1", overflow);
        end
        tick(S);
        model = '0;
        model_aux = '0;
        n_tests++;
        if (scan.col_out !== 12'hFFF || scan.row_out !== 16'hFFFF || aux !== 2'b00) begin
            n_fail++; $display("FAIL burst_resync: got %h/%h aux=%b want fff/ffff aux=00",
                               scan.col_out, scan.row_out, aux);
        end
        n_tests++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL burst_ovf_clr: got ovf=%b busy=%b want 0 0", overflow, busy);
        end
    endtask

    task automatic test_aux_unmapped();
        send(9'h012, 1'b1, 1'b1, 1'b1, 0, 0);
        tick(3);
        apply_next();
        scan.row_in = '0;
        #1;
        n_tests++;
        if (aux !== model_aux || aux !== 2'b01) begin
            n_fail++; $display("FAIL lshift_aux: got %b want 01", aux);
        end
        n_tests++;
        if (scan.col_out !== exp_col(scan.row_in)) begin
            n_fail++; $display("FAIL lshift_matrix: got %h want %h", scan.col_out, exp_col(scan.row_in));
        end
        wait_idle("lshift");
        send(9'h012, 1'b0, 1'b1, 1'b1, 0, 0);
        tick(3);
        apply_next();
        n_tests++;
        if (aux !== 2'b00) begin
            n_fail++; $display("FAIL lshift_release: got %b want 00", aux);
        end
        wait_idle("lshift_rel");
        send(9'h0FF, 1'b1, 1'b0, 1'b0, 0, 0);
        tick(1);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_busy: got %b want 0", busy);
        end
        mode = 2'd2;
        send(9'h01C, 1'b1, 1'b0, 1'b0, 8, 2);
        tick(3);
        n_tests++;
        if (busy !== 1'b0 || scan.col_out !== 12'hFFF) begin
            n_fail++; $display("FAIL reserved_mode: got busy=%b col=%h want 0 fff", busy, scan.col_out);
        end
        mode = 2'd0;
    endtask

    task automatic test_mode_mx();
        mode = 2'd1;
        send(9'h005, 1'b1, 1'b1, 1'b0, 9, 5);
        tick(1);
        mode = 2'd0;
        tick(2);
        apply_next();
        probe(9, 5);
        n_tests++;
        if (scan.col_out !== 12'hFDF) begin
            n_fail++; $display("FAIL mx_col_out: got %h want fdf", scan.col_out);
        end
        probe(12, 0);
        n_tests++;
        if (scan.col_out !== exp_col(scan.row_in) || scan.row_out !== exp_row(scan.col_in)) begin
            n_fail++; $display("FAIL mx_std_pos: got %h/%h want %h/%h", scan.col_out,
                               scan.row_out, exp_col(scan.row_in), exp_row(scan.col_in));
        end
        wait_idle("mx_press");
        mode = 2'd1;
        send(9'h005, 1'b0, 1'b1, 1'b0, 9, 5);
        tick(3);
        apply_next();
        mode = 2'd0;
        probe(9, 5);
        n_tests++;
        if (scan.col_out !== 12'hFFF) begin
            n_fail++; $display("FAIL mx_release: got %h want fff", scan.col_out);
        end
        wait_idle("mx_release");
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 4; i++) begin
            send(bk[i], 1'b1, 1'b1, 1'b0, br[i], bc[i]);
            tick(1);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sbq.delete();
        model = '0;
        model_aux = '0;
        scan.row_in = '0;
        scan.col_in = '0;
        #1;
        n_tests++;
        if (scan.col_out !== 12'hFFF || scan.row_out !== 16'hFFFF || aux !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_outs: got %h/%h aux=%b want fff/ffff aux=00",
                               scan.col_out, scan.row_out, aux);
        end
        n_tests++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_flags: got ovf=%b busy=%b want 0 0", overflow, busy);
        end
        tick(4 * S + 4);
        n_tests++;
        if (scan.col_out !== 12'hFFF || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_apply: got %h busy=%b want fff 0", scan.col_out, busy);
        end
    endtask

    initial begin
        scan.row_in = '1;
        scan.col_in = '1;
        test_reset();
        test_press_a();
        test_hold();
        test_burst_overflow();
        test_aux_unmapped();
        test_mode_mx();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
